// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regs
// Purpose  : APB completer owning a word-addressed register file with
//            programmable wait states and error response. Optional
//            byte-strobe writes are enabled by defining APB_SLV_PSTRB_EN.
// Revision : 1.0
// ============================================================================
module apb_slave_regs #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];

  logic [STRB_W-1:0]   bus_strb;
  logic [IDX_W-1:0]    idx;
  logic                acc_err;
  logic [DATA_W-1:0]   rd_word;

`ifdef APB_SLV_PSTRB_EN
  assign bus_strb = PSTRB;
`else
  assign bus_strb = '1;
`endif

  // Decode always works on the copy latched at setup, never the live bus.
  assign idx     = addr_q[ADDR_W-1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) ||
                   (idx >= IDX_W'(NUM_REGS)) ||
                   (write_q && (idx == '0));

  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    pready_d  = 1'b0;
    regs_d    = regs_q;

    case (state_q)
      ST_IDLE: begin
        // PSEL with PENABLE already high is a lingering master, not a setup.
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = bus_strb;
          if (WAIT_STATES == 0) begin
            state_d  = ST_DONE;
            pready_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          pready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // The edge closing the PREADY cycle commits the write or loads read data.
        state_d   = ST_IDLE;
        pslverr_d = acc_err;
        if (acc_err) begin
          if (!write_q) prdata_d = '0;
        end else if (write_q) begin
          for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
              end
            end
          end
        end else begin
          prdata_d = rd_word;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regs
// Purpose  : Randomized self-checking bench for apb_slave_regs against an
//            array-based register model (APB_SLV_PSTRB_EN adds strobe tests).
// Revision : 1.0
// ============================================================================
module tb_apb_slave_regs;

  parameter int WS = 1;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          NREGS  = 8;
  localparam logic [31:0] ID     = 32'hA5B0_0001;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] model [0:NREGS-1];

  always #5 PCLK = ~PCLK;

  apb_slave_regs #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_REGS   (NREGS),
    .WAIT_STATES(WS),
    .ID_VALUE   (ID)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB  (PSTRB),
`endif
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [3:0] eff_strb(input logic [3:0] s);
`ifdef APB_SLV_PSTRB_EN
    return s;
`else
    return 4'hF;
`endif
  endfunction

  task automatic model_reset();
    model[0] = ID;
    for (int i = 1; i < NREGS; i++) model[i] = 32'h0;
  endtask

  // Reference behaviour: returns expected error and (for reads) data.
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] strb, output logic [31:0] rd, output logic err);
    int idx;
    logic [3:0] s;
    idx = int'(addr >> 2);
    s   = eff_strb(strb);
    err = (addr % 4 != 0) || (idx >= NREGS) || (wr && idx == 0);
    rd  = 32'h0;
    if (!err && wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
    end else if (!err) begin
      rd = model[idx];
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input bit linger,
                          output logic [31:0] rd, output logic err);
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom);
    n = 0;
    while (!PREADY && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("wait_cycles", n, WS);
    @(posedge PCLK); #1;
    chk("pready_one_cycle", {31'h0, PREADY}, 32'h0);
    if (!linger) begin PSEL = 1'b0; PENABLE = 1'b0; end
    rd  = PRDATA;
    err = PSLVERR;
    if (linger) begin
      repeat (2) begin
        @(posedge PCLK); #1;
        chk("linger_no_access", {31'h0, PREADY}, 32'h0);
      end
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input bit linger);
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    apb_xfer(wr, addr, wd, strb, linger, rd, err);
    model_access(wr, addr, wd, strb, exp_rd, exp_err);
    chk(wr ? "wr_pslverr" : "rd_pslverr", {31'h0, err}, {31'h0, exp_err});
    if (!wr) chk("rd_prdata", rd, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", {31'h0, PREADY}, 32'h0);
    chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Basic write/read and hold after PSEL drops
    do_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h08, 32'h0, 4'hF, 1'b0);
    repeat (3) begin
      @(posedge PCLK); #1;
      chk("hold_prdata", PRDATA, 32'hDEAD_BEEF);
      chk("hold_pslverr", {31'h0, PSLVERR}, 32'h0);
    end

    // ID register and its write protection
    do_xfer(1'b0, 32'h00, 32'h0, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h00, 32'h1234, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h00, 32'h0, 4'hF, 1'b0);

    // Out-of-range and misaligned accesses
    do_xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h06, 32'hFFFF_FFFF, 4'hF, 1'b0);
    for (int i = 0; i < NREGS; i++) do_xfer(1'b0, 32'(i * 4), 32'h0, 4'hF, 1'b0);

    // Back-to-back with lingering master
    do_xfer(1'b1, 32'h04, 32'h1, 4'hF, 1'b1);
    do_xfer(1'b1, 32'h08, 32'h2, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h08, 32'h0, 4'hF, 1'b1);

`ifdef APB_SLV_PSTRB_EN
    do_xfer(1'b1, 32'h04, 32'h1122_3344, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101, 1'b0);
    do_xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0);
    chk("strb_model", model[1], 32'h11BB_33DD);
    do_xfer(1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    do_xfer(1'b0, 32'h04, 32'h0, 4'hF, 1'b0);
`endif

    // Abort: PSEL dropped right after setup (with no wait states the write already completes)
    do_xfer(1'b1, 32'h08, 32'h5555_AAAA, 4'hF, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h0BAD_0BAD; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_pready", {31'h0, PREADY}, 32'h0);
    if (WS == 0) model[2] = 32'h0BAD_0BAD;
    repeat (2) @(posedge PCLK);
    #1;
    do_xfer(1'b0, 32'h08, 32'h0, 4'hF, 1'b0);

    // Asynchronous reset in the middle of a transfer
    do_xfer(1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h0C, 32'h0, 4'hF, 1'b0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'h1111_2222;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1;
    chk("midrst_pready", {31'h0, PREADY}, 32'h0);
    chk("midrst_pslverr", {31'h0, PSLVERR}, 32'h0);
    chk("midrst_prdata", PRDATA, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
    @(posedge PCLK); #1;
    do_xfer(1'b0, 32'h0C, 32'h0, 4'hF, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      a = 32'(($urandom % (NREGS + 2)) * 4);
      if ($urandom % 6 == 0) a = a + ($urandom % 4);
      d = $urandom;
      do_xfer(1'($urandom % 2), a, d, 4'($urandom), ($urandom % 5) == 0);
    end
    for (int i = 0; i < NREGS; i++) do_xfer(1'b0, 32'(i * 4), 32'h0, 4'hF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
